multicycle_mem_interface: RTL and testbench

- Memory-side stage of the multicycle core: sits between the datapath's memory port and the external bus.
- Turns one core access into one bus transaction. Handles byte-lane alignment, write-data replication, byte-enable generation, read sign/zero extension and misalignment detection.
- Waits a variable number of cycles for a bus acknowledge; the control path stalls until resp_valid.

---
 rtl/multicycle_mem_interface_pkg.sv | 25 ++
 rtl/multicycle_mem_interface_data_align.sv | 63 ++++++
 rtl/multicycle_mem_interface.sv | 166 ++++++++++++++++
 tb/tb_multicycle_mem_interface.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_mem_interface_pkg.sv
// +--------------------------------------------------------------------------+
// | multicycle_mem_interface_pkg                                             |
// | Shared memory access format encodings and interface FSM state type.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package multicycle_mem_interface_pkg;

  // RISC-V funct3 load/store width encodings
  localparam logic [2:0] MEM_FMT_B  = 3'b000;
  localparam logic [2:0] MEM_FMT_H  = 3'b001;
  localparam logic [2:0] MEM_FMT_W  = 3'b010;
  localparam logic [2:0] MEM_FMT_BU = 3'b100;
  localparam logic [2:0] MEM_FMT_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_mem_interface_data_align.sv
// +--------------------------------------------------------------------------+
// | mem_data_align                                                           |
// | Byte lanes, store replication, load shift/extension, access legality.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_data_align
  import multicycle_mem_interface_pkg::*;
(
  input  logic [2:0]  req_format,
  input  logic [1:0]  req_offset,
  input  logic        req_write,
  input  logic [31:0] req_write_data,
  output logic [3:0]  byte_enable,
  output logic [31:0] write_data,
  output logic        access_error,
  input  logic [2:0]  load_format,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [31:0] load_shifted;

  always_comb begin
    byte_enable  = 4'b0000;
    write_data   = req_write_data;
    access_error = 1'b0;
    case (req_format)
      MEM_FMT_B, MEM_FMT_BU: begin
        byte_enable  = 4'b0001 << req_offset;
        write_data   = {4{req_write_data[7:0]}};
        access_error = req_write && (req_format == MEM_FMT_BU);
      end
      MEM_FMT_H, MEM_FMT_HU: begin
        byte_enable  = 4'b0011 << req_offset;
        write_data   = {2{req_write_data[15:0]}};
        access_error = req_offset[0] || (req_write && (req_format == MEM_FMT_HU));
      end
      MEM_FMT_W: begin
        byte_enable  = 4'b1111;
        access_error = (req_offset != 2'b00);
      end
      default: access_error = 1'b1;
    endcase
  end

  // Addressed lane moves down to bit 0 before extension
  always_comb begin
    load_shifted = load_word >> {load_offset, 3'b000};
    case (load_format)
      MEM_FMT_B:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      MEM_FMT_BU: load_data = {24'd0, load_shifted[7:0]};
      MEM_FMT_H:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      MEM_FMT_HU: load_data = {16'd0, load_shifted[15:0]};
      default:    load_data = load_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_mem_interface.sv
// +--------------------------------------------------------------------------+
// | multicycle_mem_interface                                                 |
// | Core memory port to bus bridge; optional bus timeout: MEM_IF_TIMEOUT_EN. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_mem_interface
  import multicycle_mem_interface_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_format,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic        bus_ack
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_err;
  logic [31:0] load_data;

`ifdef MEM_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  mem_data_align u_align (
    .req_format     (req_format),
    .req_offset     (req_address[1:0]),
    .req_write      (req_write),
    .req_write_data (req_write_data),
    .byte_enable    (req_be),
    .write_data     (req_wdata),
    .access_error   (req_err),
    .load_format    (fmt_q),
    .load_offset    (off_q),
    .load_word      (bus_read_data),
    .load_data      (load_data)
  );

  // Response fields default to zero so they are only non-zero during RESP
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
    rdata_d = 32'd0;
    err_d   = 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
            addr_d  = {req_address[31:2], 2'b00};
            wdata_d = req_wdata;
            be_d    = req_be;
            write_d = req_write;
            fmt_d   = req_format;
            off_d   = req_address[1:0];
`ifdef MEM_IF_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d = RESP;
          rdata_d = write_q ? 32'd0 : load_data;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      fmt_q   <= 3'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
      err_q   <= err_d;
`ifdef MEM_IF_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_read_data   = rdata_q;
  assign resp_error       = err_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_byte_enable  = be_q;
  assign bus_read_enable  = (state_q == BUS) && !write_q;
  assign bus_write_enable = (state_q == BUS) && write_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_mem_interface.sv
// +--------------------------------------------------------------------------+
// | tb_multicycle_mem_interface                                              |
// | Directed vector bench for multicycle_mem_interface (MEM_IF_TIMEOUT_EN).  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_mem_interface;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_format = 3'b000;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_write_data = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic [31:0] bus_address;
  logic [31:0] bus_read_data = 32'd0;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_mem_interface #(.TIMEOUT_CYCLES(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_format       (req_format),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .resp_valid       (resp_valid),
    .resp_read_data   (resp_read_data),
    .resp_error       (resp_error),
    .bus_address      (bus_address),
    .bus_read_data    (bus_read_data),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_ack          (bus_ack)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  fmt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          wait_cycles;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] fmt, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid      = 1'b1;
    req_write      = wr;
    req_format     = fmt;
    req_address    = addr;
    req_write_data = wdata;
  endtask

  // Scramble request inputs after acceptance; they must be don't-care
  task automatic drop_req();
    req_valid      = 1'b0;
    req_write      = ~req_write;
    req_format     = 3'b111;
    req_address    = ~req_address;
    req_write_data = ~req_write_data;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int en_cycles;
    drive_req(v.wr, v.fmt, v.addr, v.wdata);
    chk1({tag, " req_ready"}, req_ready, 1'b1);
    tick();
    drop_req();
    if (v.exp_err) begin
      chk1({tag, " resp_valid"}, resp_valid, 1'b1);
      chk1({tag, " resp_error"}, resp_error, 1'b1);
      chk({tag, " rdata"}, resp_read_data, 32'd0);
      chk1({tag, " no bus"}, bus_read_enable | bus_write_enable, 1'b0);
      tick();
      chk1({tag, " resp_valid drop"}, resp_valid, 1'b0);
      chk1({tag, " ready again"}, req_ready, 1'b1);
    end else begin
      chk({tag, " bus_address"}, bus_address, {v.addr[31:2], 2'b00});
      chk({tag, " byte_enable"}, {28'd0, bus_byte_enable}, {28'd0, v.exp_be});
      if (v.wr) chk({tag, " bus_write_data"}, bus_write_data, v.exp_bwdata);
      en_cycles = 0;
      for (int i = 0; i <= v.wait_cycles; i++) begin
        if (i == v.wait_cycles) begin
          bus_ack       = 1'b1;
          bus_read_data = v.rword;
        end else begin
          bus_read_data = 32'h5A5A_A5A5;
        end
        if (v.wr ? (bus_write_enable && !bus_read_enable)
                 : (bus_read_enable && !bus_write_enable)) en_cycles++;
        tick();
      end
      bus_ack = 1'b0;
      chk({tag, " enable cycles"}, 32'(en_cycles), 32'(v.wait_cycles + 1));
      chk1({tag, " resp_valid"}, resp_valid, 1'b1);
      chk1({tag, " resp_error"}, resp_error, 1'b0);
      chk({tag, " rdata"}, resp_read_data, v.exp_rdata);
      chk1({tag, " enables off"}, bus_read_enable | bus_write_enable, 1'b0);
      tick();
      chk1({tag, " resp_valid drop"}, resp_valid, 1'b0);
      chk1({tag, " ready again"}, req_ready, 1'b1);
    end
  endtask

  vec_t vecs[15];

  initial begin
    vec_t v;
    int   en_cycles;
    logic seen;

    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'hFFFF_FFFF, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'hABCD_0000, 0, 1'b0, 4'b1100, 32'h0, 32'h0000_ABCD};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hABCD_0000, 2, 1'b0, 4'b1100, 32'h0, 32'hFFFF_ABCD};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0, 4'b0010, 32'h7878_7878, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 3'b001, 32'h0000_0011, 32'h0000_1111, 32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00AA, 32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'h1234_8765, 0, 1'b0, 4'b0011, 32'h0, 32'hFFFF_8765};
    vecs[13] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,         32'h0000_007F, 0, 1'b0, 4'b0001, 32'h0, 32'h0000_007F};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_0006, 32'h5555_5555, 32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk1("reset req_ready", req_ready, 1'b1);
    chk1("reset resp_valid", resp_valid, 1'b0);
    chk1("reset resp_error", resp_error, 1'b0);
    chk("reset resp_read_data", resp_read_data, 32'd0);
    chk("reset bus_address", bus_address, 32'd0);
    chk("reset bus_write_data", bus_write_data, 32'd0);
    chk("reset bus_byte_enable", {28'd0, bus_byte_enable}, 32'd0);
    chk1("reset bus enables", bus_read_enable | bus_write_enable, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stray bus_ack while idle
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk1("idle ack resp_valid", resp_valid, 1'b0);
    chk1("idle ack ready", req_ready, 1'b1);

    // New request while busy must be ignored
    drive_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    drive_req(1'b1, 3'b010, 32'h0000_0700, 32'h1111_2222);
    chk1("busy ready low", req_ready, 1'b0);
    tick();
    chk("busy address held", bus_address, 32'h0000_0300);
    chk1("busy still read", bus_read_enable && !bus_write_enable, 1'b1);
    req_valid     = 1'b0;
    bus_ack       = 1'b1;
    bus_read_data = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    chk("busy rdata", resp_read_data, 32'h0BAD_F00D);
    tick();
    chk1("busy back idle", req_ready, 1'b1);

    // Reset in the middle of a bus access
    drive_req(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    tick();
    drop_req();
    chk1("mid reset bus active", bus_read_enable, 1'b1);
    reset = 1'b1;
    tick();
    chk1("mid reset enables", bus_read_enable | bus_write_enable, 1'b0);
    chk1("mid reset ready", req_ready, 1'b1);
    chk1("mid reset resp_valid", resp_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk1("post reset resp_valid", resp_valid, 1'b0);
    v = '{1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h1357_9BDF, 1, 1'b0, 4'b1111, 32'h0, 32'h1357_9BDF};
    run_vec(v, "post reset LW");

`ifdef MEM_IF_TIMEOUT_EN
    // No ack: abort after 16 BUS cycles
    drive_req(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    drop_req();
    bus_read_data = 32'hFFFF_FFFF;
    en_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus_read_enable) en_cycles++;
      tick();
    end
    chk1("timeout resp seen", seen, 1'b1);
    chk("timeout bus cycles", 32'(en_cycles), 32'd16);
    chk1("timeout error", resp_error, 1'b1);
    chk("timeout rdata", resp_read_data, 32'd0);
    tick();
    v = '{1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h2468_ACE0, 15, 1'b0, 4'b1111, 32'h0, 32'h2468_ACE0};
    run_vec(v, "ack on last cycle");
`else
    // Without the timeout the bus waits indefinitely
    v = '{1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h2468_ACE0, 24, 1'b0, 4'b1111, 32'h0, 32'h2468_ACE0};
    run_vec(v, "long wait");
    seen = 1'b0;
    en_cycles = 0;
    chk1("long wait unused", seen, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
